// File: rtl/roach_clk_rst_pkg.sv
// Shared types and widths for the ROACH2 clock/reset sequencer.
package roach_clk_rst_pkg;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t MMCM_RST  = 3'd0;
  localparam state_t WAIT_LOCK = 3'd1;
  localparam state_t SETTLE    = 3'd2;
  localparam state_t IDLY_RST  = 3'd3;
  localparam state_t WAIT_RDY  = 3'd4;
  localparam state_t RUN       = 3'd5;
  localparam state_t RETRY     = 3'd6;
  localparam state_t FAIL      = 3'd7;

  // Asynchronous clock-infrastructure status, synchronised as one bundle
  typedef struct packed {
    logic sys_lock;
    logic aux_lock;
    logic idelay_rdy;
  } clk_status_t;

  localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

  function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
    return (v == RETRY_SAT) ? v : v + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/roach_sync_2ff.sv
// Two-flop synchroniser, async active-low reset to 0.
module roach_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/roach_clk_rst_sequencer.sv
// Start-up sequencer for the ROACH2 MMCMs and IDELAYCTRL; releases the
// system reset only after locks and idelay_rdy are qualified.
module roach_clk_rst_sequencer
  import roach_clk_rst_pkg::*;
#(
  parameter int unsigned MMCM_RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT      = 50000,
  parameter int unsigned SETTLE_CYCLES     = 1024,
  parameter int unsigned IDELAY_RST_CYCLES = 64,
  parameter int unsigned RDY_TIMEOUT       = 4096,
  parameter int unsigned MAX_RETRIES       = 3
) (
  input  logic               epb_clk,
  input  logic               epb_rst_n,
  input  logic               sys_clk_lock,
  input  logic               aux_clk_lock,
  input  logic               aux_lock_en,
  input  logic               idelay_rdy,
  input  logic               soft_rst,
  output logic               mmcm_reset,
  output logic               idelay_rst,
  output logic               op_power_on_rst,
  output logic               seq_done,
  output logic               seq_fail,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count
);

  localparam logic [CNT_W-1:0]   MMCM_LAST   = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   IDLY_LAST   = CNT_W'(IDELAY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RDY_LAST    = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  clk_status_t raw_status;
  clk_status_t sync_status;

  assign raw_status.sys_lock   = sys_clk_lock;
  assign raw_status.aux_lock   = aux_clk_lock;
  assign raw_status.idelay_rdy = idelay_rdy;

  roach_sync_2ff #(
    .WIDTH($bits(clk_status_t))
  ) u_status_sync (
    .clk  (epb_clk),
    .rst_n(epb_rst_n),
    .d    (raw_status),
    .q    (sync_status)
  );

  logic lock_ok;
  logic rdy_s;

  assign lock_ok = sync_status.sys_lock & (sync_status.aux_lock | ~aux_lock_en);
  assign rdy_s   = sync_status.idelay_rdy;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [RETRY_W-1:0] retry_d;
  logic               lost_d;
  logic               mmcm_d;
  logic               idly_d;
  logic               por_d;
  logic               done_d;
  logic               fail_d;

  always_ff @(posedge epb_clk or negedge epb_rst_n) begin
    if (!epb_rst_n) begin
      state_q         <= MMCM_RST;
      cnt_q           <= '0;
      mmcm_reset      <= 1'b1;
      idelay_rst      <= 1'b1;
      op_power_on_rst <= 1'b1;
      seq_done        <= 1'b0;
      seq_fail        <= 1'b0;
      lock_lost       <= 1'b0;
      retry_count     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mmcm_reset      <= mmcm_d;
      idelay_rst      <= idly_d;
      op_power_on_rst <= por_d;
      seq_done        <= done_d;
      seq_fail        <= fail_d;
      lock_lost       <= lost_d;
      retry_count     <= retry_d;
    end
  end

  // Next state, counter and bookkeeping; outputs are decoded from the next
  // state so each registered output lines up with the state it belongs to.
  always_comb begin
    state_d = state_q;
    retry_d = retry_count;
    lost_d  = lock_lost;
    mmcm_d  = 1'b1;
    idly_d  = 1'b1;
    por_d   = 1'b1;
    done_d  = 1'b0;
    fail_d  = 1'b0;

    case (state_q)
      MMCM_RST: begin
        if (cnt_q == MMCM_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_ok)                state_d = SETTLE;
        else if (cnt_q == LOCK_LAST) state_d = RETRY;
      end
      SETTLE: begin
        if (!lock_ok)                  state_d = WAIT_LOCK;
        else if (cnt_q == SETTLE_LAST) state_d = IDLY_RST;
      end
      IDLY_RST: begin
        if (!lock_ok)                state_d = RETRY;
        else if (cnt_q == IDLY_LAST) state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (!lock_ok)               state_d = RETRY;
        else if (rdy_s)             state_d = RUN;
        else if (cnt_q == RDY_LAST) state_d = RETRY;
      end
      RUN: begin
        // Losing lock in RUN restarts cleanly and is not a failed attempt
        if (!lock_ok) begin
          lost_d  = 1'b1;
          retry_d = '0;
          state_d = MMCM_RST;
        end else if (!rdy_s) begin
          state_d = MMCM_RST;
        end
      end
      RETRY: begin
        retry_d = retry_inc(retry_count);
        state_d = (retry_d == RETRY_LIMIT) ? FAIL : MMCM_RST;
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = MMCM_RST;
      end
    endcase

    if (soft_rst) begin
      state_d = MMCM_RST;
      retry_d = '0;
      lost_d  = 1'b0;
    end

    cnt_d = (soft_rst || (state_d != state_q)) ? '0 : cnt_q + CNT_W'(1);

    case (state_d)
      WAIT_LOCK, SETTLE, IDLY_RST: begin
        mmcm_d = 1'b0;
      end
      WAIT_RDY: begin
        mmcm_d = 1'b0;
        idly_d = 1'b0;
      end
      RUN: begin
        mmcm_d = 1'b0;
        idly_d = 1'b0;
        por_d  = 1'b0;
        done_d = 1'b1;
      end
      FAIL: begin
        fail_d = 1'b1;
      end
      default: begin
        mmcm_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_roach_clk_rst_sequencer.sv
// Bench for roach_clk_rst_sequencer: reactive board model, cycle-level
// reference model, vector table, directed corner cases and random stress.
module tb_roach_clk_rst_sequencer;

  localparam int T_MMCM   = 4;
  localparam int T_LOCK   = 20;
  localparam int T_SETTLE = 8;
  localparam int T_IDLY   = 4;
  localparam int T_RDY    = 10;
  localparam int T_MAXR   = 3;
  localparam int NEVER    = 1000000;
  localparam logic [9:0] RST_VEC = 10'b1110000000;

  logic       epb_clk      = 1'b0;
  logic       epb_rst_n    = 1'b0;
  logic       sys_clk_lock = 1'b0;
  logic       aux_clk_lock = 1'b0;
  logic       aux_lock_en  = 1'b1;
  logic       idelay_rdy   = 1'b0;
  logic       soft_rst     = 1'b0;
  logic       mmcm_reset;
  logic       idelay_rst;
  logic       op_power_on_rst;
  logic       seq_done;
  logic       seq_fail;
  logic       lock_lost;
  logic [3:0] retry_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Board model knobs: cycles after reset release until the signal asserts
  int lock_dly = 5;
  int aux_dly  = 5;
  int rdy_dly  = 3;
  bit aux_kill = 1'b0;
  int mmcm_low_age = 0;
  int idly_low_age = 0;

  always #5 epb_clk = ~epb_clk;

  roach_clk_rst_sequencer #(
    .MMCM_RST_CYCLES  (T_MMCM),
    .LOCK_TIMEOUT     (T_LOCK),
    .SETTLE_CYCLES    (T_SETTLE),
    .IDELAY_RST_CYCLES(T_IDLY),
    .RDY_TIMEOUT      (T_RDY),
    .MAX_RETRIES      (T_MAXR)
  ) dut (
    .epb_clk        (epb_clk),
    .epb_rst_n      (epb_rst_n),
    .sys_clk_lock   (sys_clk_lock),
    .aux_clk_lock   (aux_clk_lock),
    .aux_lock_en    (aux_lock_en),
    .idelay_rdy     (idelay_rdy),
    .soft_rst       (soft_rst),
    .mmcm_reset     (mmcm_reset),
    .idelay_rst     (idelay_rst),
    .op_power_on_rst(op_power_on_rst),
    .seq_done       (seq_done),
    .seq_fail       (seq_fail),
    .lock_lost      (lock_lost),
    .retry_count    (retry_count)
  );

  // ---------------- reference model ----------------
  typedef enum int {P_HOLD, P_LOCKWAIT, P_STABLE, P_DLYRST, P_RDYWAIT, P_UP, P_RETRY, P_DEAD} phase_t;
  phase_t m_phase   = P_HOLD;
  int     m_age     = 0;
  int     m_retries = 0;
  bit     m_lost    = 1'b0;
  bit [1:0] h_sys = '0;
  bit [1:0] h_aux = '0;
  bit [1:0] h_rdy = '0;

  function automatic void m_enter(input phase_t p);
    m_phase = p;
    m_age   = 0;
  endfunction

  // Helper: stay in the phase until 'len' cycles have elapsed, then go on
  function automatic void m_dwell(input int len, input phase_t nxt);
    if (m_age + 1 >= len) m_enter(nxt);
    else m_age++;
  endfunction

  function automatic void model_step();
    bit ok;
    bit rdy;
    ok  = h_sys[1] && (h_aux[1] || !aux_lock_en);
    rdy = h_rdy[1];
    h_sys = {h_sys[0], sys_clk_lock};
    h_aux = {h_aux[0], aux_clk_lock};
    h_rdy = {h_rdy[0], idelay_rdy};
    if (soft_rst) begin
      m_enter(P_HOLD);
      m_retries = 0;
      m_lost    = 1'b0;
      return;
    end
    case (m_phase)
      P_HOLD:     m_dwell(T_MMCM, P_LOCKWAIT);
      P_LOCKWAIT: if (ok) m_enter(P_STABLE); else m_dwell(T_LOCK, P_RETRY);
      P_STABLE:   if (!ok) m_enter(P_LOCKWAIT); else m_dwell(T_SETTLE, P_DLYRST);
      P_DLYRST:   if (!ok) m_enter(P_RETRY); else m_dwell(T_IDLY, P_RDYWAIT);
      P_RDYWAIT: begin
        if (!ok)      m_enter(P_RETRY);
        else if (rdy) m_enter(P_UP);
        else          m_dwell(T_RDY, P_RETRY);
      end
      P_UP: begin
        if (!ok) begin
          m_lost    = 1'b1;
          m_retries = 0;
          m_enter(P_HOLD);
        end else if (!rdy) begin
          m_enter(P_HOLD);
        end
      end
      P_RETRY: begin
        m_retries = (m_retries < 15) ? m_retries + 1 : 15;
        m_enter((m_retries == T_MAXR) ? P_DEAD : P_HOLD);
      end
      default: ;
    endcase
  endfunction

  always @(posedge epb_clk or negedge epb_rst_n) begin
    if (!epb_rst_n) begin
      m_enter(P_HOLD);
      m_retries = 0;
      m_lost    = 1'b0;
      h_sys = '0;
      h_aux = '0;
      h_rdy = '0;
    end else begin
      model_step();
    end
  end

  function automatic logic [9:0] model_out();
    logic mm, id, por, dn, fl;
    mm  = (m_phase == P_HOLD) || (m_phase == P_RETRY) || (m_phase == P_DEAD);
    id  = !((m_phase == P_RDYWAIT) || (m_phase == P_UP));
    por = (m_phase != P_UP);
    dn  = (m_phase == P_UP);
    fl  = (m_phase == P_DEAD);
    return {mm, id, por, dn, fl, m_lost, 4'(m_retries)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {mmcm_reset, idelay_rst, op_power_on_rst, seq_done, seq_fail, lock_lost, retry_count};
  endfunction

  // ---------------- checking / stimulus helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic respond();
    if (mmcm_reset) mmcm_low_age = 0; else mmcm_low_age++;
    if (idelay_rst) idly_low_age = 0; else idly_low_age++;
    sys_clk_lock = (mmcm_low_age >= lock_dly);
    aux_clk_lock = (mmcm_low_age >= aux_dly) && !aux_kill;
    idelay_rdy   = (idly_low_age >= rdy_dly);
  endtask

  task automatic tick();
    @(negedge epb_clk);
    cyc++;
    check("model", 32'(dut_vec()), 32'(model_out()));
    soft_rst = 1'b0;
    respond();
  endtask

  task automatic pulse_soft();
    soft_rst = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!seq_done && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(seq_done), 32'd1);
  endtask

  task automatic count_mmcm_pulse(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 40 && mmcm_reset; i++) begin
      n++;
      tick();
    end
    check(name, 32'(n), 32'd4);
  endtask

  typedef struct {
    bit aux_en;
    int lock_d;
    int aux_d;
    int rdy_d;
    int run;
    bit exp_done;
    bit exp_fail;
    int exp_retry;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #3000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit hit;

    vecs[0] = '{1'b1, 5,     5,     3,     80,  1'b1, 1'b0, 0};
    vecs[1] = '{1'b0, 5,     NEVER, 3,     80,  1'b1, 1'b0, 0};
    vecs[2] = '{1'b1, 5,     NEVER, 3,     120, 1'b0, 1'b1, 3};
    vecs[3] = '{1'b1, 25,    25,    3,     120, 1'b0, 1'b1, 3};
    vecs[4] = '{1'b1, 15,    15,    3,     120, 1'b1, 1'b0, 0};
    vecs[5] = '{1'b1, 5,     5,     NEVER, 160, 1'b0, 1'b1, 3};

    // Reset state
    repeat (3) tick();
    check("reset_outputs", 32'(dut_vec()), 32'(RST_VEC));

    // Clean bring-up
    epb_rst_n = 1'b1;
    count_mmcm_pulse("mmcm_pulse_len");
    wait_done("bringup_done", 100);
    check("bringup_por", 32'(op_power_on_rst), 32'd0);
    check("bringup_retry", 32'(retry_count), 32'd0);

    // Vector table
    foreach (vecs[i]) begin
      aux_lock_en = vecs[i].aux_en;
      lock_dly    = vecs[i].lock_d;
      aux_dly     = vecs[i].aux_d;
      rdy_dly     = vecs[i].rdy_d;
      pulse_soft();
      repeat (vecs[i].run) tick();
      check($sformatf("vec%0d_done", i), 32'(seq_done), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_fail", i), 32'(seq_fail), 32'(vecs[i].exp_fail));
      check($sformatf("vec%0d_retry", i), 32'(retry_count), 32'(vecs[i].exp_retry));
    end

    // Lock glitch in SETTLE at count 5
    aux_lock_en = 1'b1;
    lock_dly = 5; aux_dly = 5; rdy_dly = 3;
    pulse_soft();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      hit = (m_phase == P_STABLE) && (m_age == 5);
    end
    check("glitch_reach_settle", 32'(hit), 32'd1);
    sys_clk_lock = 1'b0;
    tick();
    n = 1;
    while (idelay_rst && n < 100) begin
      tick();
      n++;
    end
    check("glitch_idly_fall", 32'(n), 32'd16);
    wait_done("glitch_done", 100);

    // Lock timeout to FAIL, then soft reset recovery
    lock_dly = NEVER; aux_dly = NEVER;
    pulse_soft();
    n = 0;
    while (!seq_fail && n < 500) begin
      tick();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd75);
    check("timeout_retry", 32'(retry_count), 32'd3);
    check("timeout_mmcm", 32'(mmcm_reset), 32'd1);
    pulse_soft();
    check("soft_retry_clr", 32'(retry_count), 32'd0);
    check("soft_fail_clr", 32'(seq_fail), 32'd0);
    repeat (3) tick();
    check("soft_mmcm_high", 32'(mmcm_reset), 32'd1);
    tick();
    check("soft_mmcm_low", 32'(mmcm_reset), 32'd0);

    // Aux lock loss in RUN, required and then ignored
    lock_dly = 5; aux_dly = 5; rdy_dly = 3;
    pulse_soft();
    wait_done("loss_pre_done", 100);
    check("loss_pre_flag", 32'(lock_lost), 32'd0);
    aux_kill = 1'b1;
    aux_clk_lock = 1'b0;
    n = 0;
    while (!op_power_on_rst && n < 20) begin
      tick();
      n++;
    end
    check("loss_por_latency", 32'(n), 32'd3);
    check("loss_flag", 32'(lock_lost), 32'd1);
    aux_kill = 1'b0;
    wait_done("loss_rerun_done", 100);
    check("loss_flag_sticky", 32'(lock_lost), 32'd1);
    aux_lock_en = 1'b0;
    pulse_soft();
    check("loss_flag_clr", 32'(lock_lost), 32'd0);
    wait_done("noaux_done", 100);
    aux_kill = 1'b1;
    aux_clk_lock = 1'b0;
    repeat (20) tick();
    check("noaux_still_done", 32'(seq_done), 32'd1);
    check("noaux_no_loss", 32'(lock_lost), 32'd0);
    aux_kill = 1'b0;
    aux_lock_en = 1'b1;

    // idelay_rdy timeout once, good on the next attempt
    rdy_dly = NEVER;
    pulse_soft();
    n = 0;
    while (retry_count != 4'd1 && n < 200) begin
      tick();
      n++;
    end
    check("rdy_first_retry", 32'(retry_count), 32'd1);
    rdy_dly = 3;
    wait_done("rdy_second_done", 200);
    check("rdy_retry_kept", 32'(retry_count), 32'd1);

    // Asynchronous reset while waiting for idelay_rdy
    rdy_dly = 6;
    pulse_soft();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      hit = (m_phase == P_RDYWAIT);
    end
    check("arst_reach_wait_rdy", 32'(hit), 32'd1);
    #2;
    epb_rst_n = 1'b0;
    #1;
    check("arst_outputs", 32'(dut_vec()), 32'(RST_VEC));
    tick();
    epb_rst_n = 1'b1;
    count_mmcm_pulse("arst_mmcm_pulse_len");
    wait_done("arst_rerun_done", 100);

    // Random stress against the reference model
    for (int it = 0; it < 40; it++) begin
      aux_lock_en = 1'($urandom_range(0, 1));
      lock_dly = int'($urandom_range(1, 30));
      aux_dly  = int'($urandom_range(1, 30));
      rdy_dly  = int'($urandom_range(1, 14));
      if ($urandom_range(0, 2) == 0) pulse_soft();
      for (int k = 0; k < 70; k++) begin
        tick();
        if ($urandom_range(0, 19) == 0) sys_clk_lock = 1'b0;
        if ($urandom_range(0, 19) == 0) aux_clk_lock = 1'b0;
        if ($urandom_range(0, 24) == 0) idelay_rdy = 1'b0;
        if ($urandom_range(0, 99) == 0) soft_rst = 1'b1;
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
